// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Word-organised data memory behind a simple req/ready/ack handshake. Each
//   access passes through IDLE -> (WAIT x WAIT cycles) -> RESP, and ack is
//   pulsed for the single RESP cycle. Stores honour per-byte lane enables.
//   Out-of-range word addresses complete with err=1 and touch nothing.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, 2..65536)
//   WAIT        : wait-state cycles per access (0..15)
//
// Ports
//   clk   : clock; all state changes on its rising edge
//   rst   : asynchronous, active-high reset
//   req   : access request
//   we    : 1 = store, 0 = load
//   addr  : word address (byte address bits [31:2])
//   be    : byte-lane enables, be[n] covers bits [8n+7:8n]
//   wdata : store data, already lane-replicated
//   ready : high only in IDLE; a request is accepted when req && ready
//   ack   : one-cycle completion pulse
//   rdata : load word (0 for stores and out-of-range), sampled with ack
//   err   : out-of-range flag, only ever high together with ack
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [29:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;

  // Request captured at the accept edge; inputs are ignored afterwards.
  logic        cap_we;
  logic [29:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  // With WAIT=0 the access happens on the accept edge itself, before the
  // capture registers hold the request, so IDLE takes the live inputs.
  logic        acc_we;
  logic [29:0] acc_addr;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic        in_range;
  logic        do_access;
  logic [AW-1:0] acc_idx;

  always_comb begin
    if (state == ST_IDLE) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_be    = be;
      acc_wdata = wdata;
    end else begin
      acc_we    = cap_we;
      acc_addr  = cap_addr;
      acc_be    = cap_be;
      acc_wdata = cap_wdata;
    end
  end

  // Range check on the full address so high addresses never alias low words.
  assign in_range  = ((acc_addr >> AW) == '0);
  assign acc_idx   = acc_addr[AW-1:0];
  // The access is performed on the edge that enters RESP. Gating with rst
  // keeps the unreset memory from being written while reset is held.
  assign do_access = (state_nxt == ST_RESP) && !rst;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = ST_RESP;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ready depends on state only, never on req.
  assign ready = (state == ST_IDLE);
  assign ack   = (state == ST_RESP);
  assign err   = ack & err_q;
  assign rdata = rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_be    <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == ST_IDLE && req) begin
        cap_we    <= we;
        cap_addr  <= addr;
        cap_be    <= be;
        cap_wdata <= wdata;
      end
      if (do_access) begin
        if (!in_range) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else if (acc_we) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else begin
          rdata_q <= mem[acc_idx];
          err_q   <= 1'b0;
        end
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive rst and the array
  // can map onto a plain synchronous RAM.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Directed bench for data_mem_ctrl. Three instances share one clock:
//     u=0 : WAIT=1 (store/load, byte lanes, range errors, be=0, reset in RESP)
//     u=1 : WAIT=0 (back-to-back requests with req held high)
//     u=2 : WAIT=3 (reset during WAIT aborts a store)
//   Outputs are sampled on the falling edge; inputs change on the falling edge
//   or 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_v   [3];
  logic        req_v   [3];
  logic        we_v    [3];
  logic [29:0] addr_v  [3];
  logic [3:0]  be_v    [3];
  logic [31:0] wdata_v [3];
  logic        ready_v [3];
  logic        ack_v   [3];
  logic [31:0] rdata_v [3];
  logic        err_v   [3];

  int tests = 0;
  int fails = 0;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT(1)) u_w1 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
    .be(be_v[0]), .wdata(wdata_v[0]), .ready(ready_v[0]), .ack(ack_v[0]),
    .rdata(rdata_v[0]), .err(err_v[0])
  );

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
    .be(be_v[1]), .wdata(wdata_v[1]), .ready(ready_v[1]), .ack(ack_v[1]),
    .rdata(rdata_v[1]), .err(err_v[1])
  );

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT(3)) u_w3 (
    .clk(clk), .rst(rst_v[2]), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
    .be(be_v[2]), .wdata(wdata_v[2]), .ready(ready_v[2]), .ack(ack_v[2]),
    .rdata(rdata_v[2]), .err(err_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) at falling edges until instance u is ready.
  task automatic wait_idle(input int u);
    int n = 0;
    while (ready_v[u] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", 32'(ready_v[u]), 32'd1);
  endtask

  // One full transaction; returns at the falling edge of the ack cycle.
  // lat = number of falling edges from the accept edge to the ack cycle.
  task automatic access(input int u, input logic w, input logic [29:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    wait_idle(u);
    req_v[u] = 1'b1; we_v[u] = w; addr_v[u] = a; be_v[u] = b; wdata_v[u] = d;
    @(posedge clk);
    #1;
    // Scramble the inputs: the DUT must use what it captured.
    req_v[u] = 1'b0; we_v[u] = ~w; addr_v[u] = ~a; be_v[u] = ~b; wdata_v[u] = ~d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack_v[u] !== 1'b1 && lat < 40);
    rd = rdata_v[u];
    er = err_v[u];
  endtask

  task automatic xfer(input string tag, input int u, input int wt, input logic w,
                      input logic [29:0] a, input logic [3:0] b, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(u, w, a, b, d, rd, er, lat);
    check({tag, "_lat"}, 32'(lat), 32'(wt + 1));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] sv [3];
    int          ack_cnt;
    sv[0] = 32'h0000_AAAA;
    sv[1] = 32'h0000_BBBB;
    sv[2] = 32'h0000_CCCC;

    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1; req_v[i] = 1'b0; we_v[i] = 1'b0;
      addr_v[i] = '0; be_v[i] = '0; wdata_v[i] = '0;
    end

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_ack",   32'(ack_v[0]), 32'd0);
    check("rst_err",   32'(err_v[0]), 32'd0);
    check("rst_rdata", rdata_v[0],    32'd0);
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
    @(negedge clk);
    check("rel_ready0", 32'(ready_v[0]), 32'd1);
    check("rel_ready1", 32'(ready_v[1]), 32'd1);
    check("rel_ready2", 32'(ready_v[2]), 32'd1);

    // ---------------- WAIT=1: full-word store/load ----------------
    xfer("st5",  0, 1, 1'b1, 30'd5, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge clk);
    check("st5_ack_one_cycle", 32'(ack_v[0]), 32'd0);
    xfer("ld5",  0, 1, 1'b0, 30'd5, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // ---------------- byte-lane store ----------------
    xfer("stb5", 0, 1, 1'b1, 30'd5, 4'b0100, 32'h5555_5555, 32'h0, 1'b0);
    xfer("ldb5", 0, 1, 1'b0, 30'd5, 4'b0000, 32'h0, 32'hDE55_BEEF, 1'b0);
    // rdata holds after ack; err drops with ack.
    @(negedge clk);
    check("hold_ack",   32'(ack_v[0]), 32'd0);
    check("hold_err",   32'(err_v[0]), 32'd0);
    check("hold_rdata", rdata_v[0],    32'hDE55_BEEF);

    // ---------------- out of range ----------------
    xfer("st0",    0, 1, 1'b1, 30'd0,    4'b1111, 32'hA5A5_A5A5, 32'h0, 1'b0);
    xfer("st976",  0, 1, 1'b1, 30'd976,  4'b1111, 32'h1111_2222, 32'h0, 1'b0);
    xfer("ld1024", 0, 1, 1'b0, 30'd1024, 4'b1111, 32'h0, 32'h0, 1'b1);
    xfer("st2000", 0, 1, 1'b1, 30'd2000, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xfer("st1024", 0, 1, 1'b1, 30'd1024, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xfer("ld0",    0, 1, 1'b0, 30'd0,    4'b0000, 32'h0, 32'hA5A5_A5A5, 1'b0);
    xfer("ld976",  0, 1, 1'b0, 30'd976,  4'b0000, 32'h0, 32'h1111_2222, 1'b0);

    // ---------------- be=0000 store ----------------
    xfer("st3",   0, 1, 1'b1, 30'd3, 4'b1111, 32'h1234_5678, 32'h0, 1'b0);
    xfer("st3be0",0, 1, 1'b1, 30'd3, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    xfer("ld3",   0, 1, 1'b0, 30'd3, 4'b1111, 32'h0, 32'h1234_5678, 1'b0);

    // ---------------- reset during RESP keeps committed store ----------------
    wait_idle(0);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 30'd20; be_v[0] = 4'b1111;
    wdata_v[0] = 32'h0BAD_CAFE;
    @(posedge clk);
    #1 req_v[0] = 1'b0;
    @(negedge clk);                       // WAIT cycle
    @(negedge clk);                       // RESP cycle
    check("rresp_ack_before", 32'(ack_v[0]), 32'd1);
    rst_v[0] = 1'b1;
    #1;
    check("rresp_ack_cleared", 32'(ack_v[0]), 32'd0);
    @(negedge clk);
    rst_v[0] = 1'b0;
    xfer("ld20", 0, 1, 1'b0, 30'd20, 4'b1111, 32'h0, 32'h0BAD_CAFE, 1'b0);

    // ---------------- WAIT=0: streaming with req held high ----------------
    xfer("s10", 1, 0, 1'b1, 30'd10, 4'b1111, sv[0], 32'h0, 1'b0);
    xfer("s11", 1, 0, 1'b1, 30'd11, 4'b1111, sv[1], 32'h0, 1'b0);
    xfer("s12", 1, 0, 1'b1, 30'd12, 4'b1111, sv[2], 32'h0, 1'b0);
    wait_idle(1);
    req_v[1] = 1'b1; we_v[1] = 1'b0; be_v[1] = 4'b1111; addr_v[1] = 30'd10;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("stream_ready%0d", j), 32'(ready_v[1]), 32'd1);
      check($sformatf("stream_idle_ack%0d", j), 32'(ack_v[1]), 32'd0);
      @(posedge clk);
      #1 addr_v[1] = 30'(11 + j);        // next request; must not affect this one
      @(negedge clk);
      check($sformatf("stream_busy%0d", j), 32'(ready_v[1]), 32'd0);
      check($sformatf("stream_ack%0d", j),  32'(ack_v[1]),   32'd1);
      check($sformatf("stream_rdata%0d", j), rdata_v[1], sv[j]);
      @(negedge clk);
    end
    req_v[1] = 1'b0;

    // ---------------- WAIT=3: reset in second WAIT cycle ----------------
    xfer("st7", 2, 3, 1'b1, 30'd7, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
    wait_idle(2);
    req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 30'd7; be_v[2] = 4'b1111;
    wdata_v[2] = 32'h0000_0000;
    @(posedge clk);                       // accept edge
    #1 req_v[2] = 1'b0;
    @(posedge clk);                       // first WAIT cycle ends
    @(negedge clk);                       // inside second WAIT cycle
    check("rwait_busy", 32'(ready_v[2]), 32'd0);
    rst_v[2] = 1'b1;
    #1;
    check("rwait_ack_in_rst", 32'(ack_v[2]), 32'd0);
    repeat (2) @(negedge clk);
    rst_v[2] = 1'b0;
    #1;
    check("rwait_ready_rel", 32'(ready_v[2]), 32'd1);
    ack_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack_v[2] === 1'b1) ack_cnt++;
    end
    check("rwait_no_ack", 32'(ack_cnt), 32'd0);
    xfer("ld7", 2, 3, 1'b0, 30'd7, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
